// File: rtl/switch_prog_loader_if.sv
// Operator-input / program-memory write bus between the board I/O, the
// switch_prog_loader and the proc program memory.
// master: the loader side (drives the write request and CPU control).
// slave:  the board/memory side (drives switches, buttons and write ack).
interface switch_prog_loader_if #(
    parameter int SW_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
);
    logic [SW_WIDTH-1:0]    sw;
    logic                   btn_enter;
    logic                   btn_mode;
    logic                   mem_wr_ack;
    logic                   mem_wr_en;
    logic [ADDR_WIDTH-1:0]  mem_wr_addr;
    logic [INSTR_WIDTH-1:0] mem_wr_data;
    logic                   cpu_rst;
    logic                   load_mode;
    logic                   byte_sel;

    modport master (
        input  sw, btn_enter, btn_mode, mem_wr_ack,
        output mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst, load_mode, byte_sel
    );

    modport slave (
        output sw, btn_enter, btn_mode, mem_wr_ack,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst, load_mode, byte_sel
    );
endinterface

// File: rtl/switch_prog_loader.sv
// switch_prog_loader: builds instruction words from two slide-switch bytes
// entered with a push-button and writes them into proc program memory over a
// request/ack handshake. The CPU is held in reset while loading; the mode
// button toggles between LOAD and RUN.
// Build option: define LOADER_DEBOUNCE_EN to include the button debounce
// counters; otherwise the synchronised button level is used directly.
module switch_prog_loader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SW_WIDTH        = 8,
    parameter int INSTR_WIDTH     = 16,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_prog_loader_if.master bus
);

    typedef enum logic [1:0] {
        LOAD_HI,
        LOAD_LO,
        WRITE,
        RUN
    } state_t;

    // Button index 0 = enter, 1 = mode.
    logic [1:0] raw_btn;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] level;
    logic [1:0] level_q;
    logic [1:0] press;

    state_t                 state;
    logic [SW_WIDTH-1:0]    hi_byte;
    logic                   mode_pending;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INSTR_WIDTH-1:0] data_q;
    logic                   cpu_rst_q;
    logic                   load_mode_q;
    logic                   byte_sel_q;

    logic enter_p;
    logic mode_p;

    assign raw_btn = {bus.btn_mode, bus.btn_enter};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_btn;
            sync2 <= sync1;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [2];

    // Accept a new stable level only after the synced level has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Externally debounced buttons: the synced level is taken as stable.
    // DEBOUNCE_CYCLES stays as a parameter so both builds instantiate identically.
    assign level = sync2;
    if (DEBOUNCE_CYCLES < 0) begin : g_debounce_cycles_unused
    end
`endif

    // Previous stable level, for rising-edge (press) detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= '0;
        else     level_q <= level;
    end

    assign press   = level & ~level_q;
    assign enter_p = press[0];
    assign mode_p  = press[1];

    // Loader FSM with registered outputs; mode beats enter when both pulse together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD_HI;
            hi_byte      <= '0;
            mode_pending <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cpu_rst_q    <= 1'b1;
            load_mode_q  <= 1'b1;
            byte_sel_q   <= 1'b0;
        end else begin
            case (state)
                LOAD_HI, LOAD_LO: begin
                    if (mode_p) begin
                        state       <= RUN;
                        cpu_rst_q   <= 1'b0;
                        load_mode_q <= 1'b0;
                        byte_sel_q  <= 1'b0;
                    end else if (enter_p) begin
                        if (state == LOAD_HI) begin
                            hi_byte    <= bus.sw;
                            byte_sel_q <= 1'b1;
                            state      <= LOAD_LO;
                        end else begin
                            data_q  <= {hi_byte, bus.sw};
                            wr_en_q <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_wr_ack) begin
                        wr_en_q      <= 1'b0;
                        addr_q       <= addr_q + 1'b1;
                        byte_sel_q   <= 1'b0;
                        mode_pending <= 1'b0;
                        if (mode_pending || mode_p) begin
                            state       <= RUN;
                            cpu_rst_q   <= 1'b0;
                            load_mode_q <= 1'b0;
                        end else begin
                            state <= LOAD_HI;
                        end
                    end else if (mode_p) begin
                        mode_pending <= 1'b1;
                    end
                end
                RUN: begin
                    if (mode_p) begin
                        state       <= LOAD_HI;
                        cpu_rst_q   <= 1'b1;
                        load_mode_q <= 1'b1;
                        addr_q      <= '0;
                        byte_sel_q  <= 1'b0;
                    end
                end
                default: state <= LOAD_HI;
            endcase
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = data_q;
    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.load_mode   = load_mode_q;
    assign bus.byte_sel    = byte_sel_q;

endmodule

// File: tb/tb_switch_prog_loader.sv
// Testbench for switch_prog_loader: a directed vector table, hand-written
// latency/glitch/reset/wrap sequences, and randomised operator sessions
// checked against a transaction-level model of the loader.
module tb_switch_prog_loader;

    localparam int DB = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int ACC = DB + 3;
`else
    localparam int ACC = 3;
`endif
    localparam int HOLD = ACC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_prog_loader_if #(.SW_WIDTH(8), .INSTR_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    switch_prog_loader #(
        .DEBOUNCE_CYCLES(DB),
        .SW_WIDTH(8),
        .INSTR_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model of the loader.
    bit         m_run, m_have_hi, m_writing, m_pending;
    logic [7:0] m_hi, m_addr;
    logic [15:0] m_word;

    task automatic model_reset();
        m_run = 0; m_have_hi = 0; m_writing = 0; m_pending = 0;
        m_hi = 8'h00; m_addr = 8'h00; m_word = 16'h0000;
    endtask

    task automatic model_enter(input logic [7:0] s);
        if (m_run || m_writing) return;
        if (!m_have_hi) begin
            m_hi = s; m_have_hi = 1;
        end else begin
            m_word = {m_hi, s}; m_writing = 1; m_have_hi = 0;
        end
    endtask

    task automatic model_mode();
        if (m_run) begin
            m_run = 0; m_addr = 8'h00; m_have_hi = 0;
        end else if (m_writing) begin
            m_pending = 1;
        end else begin
            m_run = 1; m_have_hi = 0;
        end
    endtask

    task automatic model_ack();
        if (!m_writing) return;
        m_writing = 0;
        m_addr = 8'((int'(m_addr) + 1) % 256);
        if (m_pending) begin
            m_run = 1; m_pending = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_byte_sel"},  {31'd0, bus.byte_sel},  {31'd0, m_have_hi | m_writing});
        check({tag, "_load_mode"}, {31'd0, bus.load_mode}, {31'd0, !m_run});
        check({tag, "_cpu_rst"},   {31'd0, bus.cpu_rst},   {31'd0, !m_run});
        check({tag, "_wr_en"},     {31'd0, bus.mem_wr_en}, {31'd0, m_writing});
        check({tag, "_addr"},      {24'd0, bus.mem_wr_addr}, {24'd0, m_addr});
        if (m_writing) check({tag, "_data"}, {16'd0, bus.mem_wr_data}, {16'd0, m_word});
    endtask

    // Clean button press: held long enough to be accepted, then released long enough to settle.
    task automatic press(input bit which, input logic [7:0] swv);
        @(posedge clk); #1;
        bus.sw = swv;
        if (which) bus.btn_mode = 1'b1;
        else       bus.btn_enter = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1;
        bus.btn_enter = 1'b0;
        bus.btn_mode  = 1'b0;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
    endtask

    // Wait d cycles checking the write request is held, then give a one-cycle ack.
    task automatic do_ack(input int d, input logic en_e, input logic [7:0] a_e, input logic [15:0] d_e);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            check("hold_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, en_e});
            check("hold_addr", {24'd0, bus.mem_wr_addr}, {24'd0, a_e});
            if (en_e) check("hold_data", {16'd0, bus.mem_wr_data}, {16'd0, d_e});
        end
        @(posedge clk); #1 bus.mem_wr_ack = 1'b1;
        @(posedge clk); #1 bus.mem_wr_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.btn_enter = 1'b0; bus.btn_mode = 1'b0; bus.mem_wr_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    typedef enum int {OP_ENTER, OP_MODE, OP_ACK} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  swv;
        int          delay;
        logic        bs, lm, cr, en;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 required");
        $fatal(1, "timeout");
    end

    initial begin
        logic        pe;
        logic [7:0]  pa;
        logic [15:0] pd;
        int          k;

        bus.sw = 8'h00; bus.btn_enter = 1'b0; bus.btn_mode = 1'b0; bus.mem_wr_ack = 1'b0;
        model_reset();

        //              op        sw     dly bs    lm    cr    en    addr   data
        vecs[0]  = '{OP_ENTER, 8'hA5, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{OP_ENTER, 8'h3C, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'hA53C};
        vecs[2]  = '{OP_ACK,   8'h00, 3,  1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'hA53C};
        vecs[3]  = '{OP_ACK,   8'h00, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'hA53C};
        vecs[4]  = '{OP_ENTER, 8'h11, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 16'hA53C};
        vecs[5]  = '{OP_MODE,  8'h00, 0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'hA53C};
        vecs[6]  = '{OP_ENTER, 8'h22, 0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'hA53C};
        vecs[7]  = '{OP_MODE,  8'h00, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'hA53C};
        vecs[8]  = '{OP_ENTER, 8'h12, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'hA53C};
        vecs[9]  = '{OP_ENTER, 8'h34, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h1234};
        vecs[10] = '{OP_MODE,  8'h00, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h1234};
        vecs[11] = '{OP_MODE,  8'h00, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h1234};
        vecs[12] = '{OP_ACK,   8'h00, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h1234};
        vecs[13] = '{OP_MODE,  8'h00, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h1234};
        vecs[14] = '{OP_ENTER, 8'h56, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'h1234};
        vecs[15] = '{OP_ENTER, 8'h78, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h5678};
        vecs[16] = '{OP_ENTER, 8'h9A, 0,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h5678};
        vecs[17] = '{OP_ACK,   8'h00, 1,  1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'h5678};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_rst",   {31'd0, bus.cpu_rst},   32'd1);
        check("rst_load_mode", {31'd0, bus.load_mode}, 32'd1);
        check("rst_wr_en",     {31'd0, bus.mem_wr_en}, 32'd0);
        check("rst_addr",      {24'd0, bus.mem_wr_addr}, 32'd0);
        check("rst_byte_sel",  {31'd0, bus.byte_sel},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        pe = 1'b0; pa = 8'h00; pd = 16'h0000;
        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_ENTER: press(1'b0, vecs[i].swv);
                OP_MODE:  press(1'b1, 8'h00);
                default:  do_ack(vecs[i].delay, pe, pa, pd);
            endcase
            check($sformatf("vec%0d_byte_sel", i),  {31'd0, bus.byte_sel},  {31'd0, vecs[i].bs});
            check($sformatf("vec%0d_load_mode", i), {31'd0, bus.load_mode}, {31'd0, vecs[i].lm});
            check($sformatf("vec%0d_cpu_rst", i),   {31'd0, bus.cpu_rst},   {31'd0, vecs[i].cr});
            check($sformatf("vec%0d_wr_en", i),     {31'd0, bus.mem_wr_en}, {31'd0, vecs[i].en});
            check($sformatf("vec%0d_addr", i),      {24'd0, bus.mem_wr_addr}, {24'd0, vecs[i].addr});
            check($sformatf("vec%0d_data", i),      {16'd0, bus.mem_wr_data}, {16'd0, vecs[i].data});
            pe = vecs[i].en; pa = vecs[i].addr; pd = vecs[i].data;
        end

        // Enter accept latency from the raw edge
        do_reset();
        @(posedge clk); #1;
        bus.sw = 8'hC3;
        bus.btn_enter = 1'b1;
        k = 0;
        while (k < 50) begin
            @(posedge clk);
            k++;
            #1;
            if (bus.byte_sel) break;
        end
        check("enter_latency", k, ACC);
        bus.btn_enter = 1'b0;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        model_enter(8'hC3);
        check_model("after_latency");

        // Short glitch vs. minimum accepted press
        do_reset();
`ifdef LOADER_DEBOUNCE_EN
        @(posedge clk); #1 bus.btn_enter = 1'b1;
        repeat (DB - 1) @(posedge clk);
        #1 bus.btn_enter = 1'b0;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        check("glitch_byte_sel", {31'd0, bus.byte_sel}, 32'd0);
        @(posedge clk); #1 bus.btn_enter = 1'b1;
        repeat (DB) @(posedge clk);
        #1 bus.btn_enter = 1'b0;
`else
        @(posedge clk); #1 bus.btn_enter = 1'b1;
        @(posedge clk);
        #1 bus.btn_enter = 1'b0;
`endif
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        check("min_press_byte_sel", {31'd0, bus.byte_sel}, 32'd1);
        check("min_press_single",   {31'd0, bus.mem_wr_en}, 32'd0);

        // Asynchronous reset during a pending write
        do_reset();
        press(1'b0, 8'h5A); model_enter(8'h5A);
        press(1'b0, 8'hA5); model_enter(8'hA5);
        check("pre_rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_wr_en",     {31'd0, bus.mem_wr_en}, 32'd0);
        check("rst_async_byte_sel",  {31'd0, bus.byte_sel},  32'd0);
        check("rst_async_load_mode", {31'd0, bus.load_mode}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        press(1'b0, 8'h77); model_enter(8'h77);
        check_model("post_rst");

        // Randomised operator sessions
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [7:0] s;
            r = $urandom_range(0, 99);
            s = 8'($urandom);
            if (r < 50) begin
                press(1'b0, s); model_enter(s);
            end else if (r < 62) begin
                press(1'b1, 8'h00); model_mode();
            end else begin
                do_ack($urandom_range(0, 4), m_writing, m_addr, m_word); model_ack();
            end
            check_model($sformatf("rand%0d", n));
        end

        // Address wrap
        do_reset();
        for (int w = 0; w < 256; w++) begin
            logic [7:0] s;
            s = 8'($urandom); press(1'b0, s); model_enter(s);
            s = 8'($urandom); press(1'b0, s); model_enter(s);
            if (w == 255) begin
                check("wrap_addr_before", {24'd0, bus.mem_wr_addr}, 32'hFF);
                check_model("wrap_last");
            end
            do_ack(0, m_writing, m_addr, m_word); model_ack();
        end
        check("wrap_addr_after", {24'd0, bus.mem_wr_addr}, 32'h00);
        check_model("wrap_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
